// File: rtl/dpa_pkg.sv
// Shared definitions for the digital photo album front end.
//   HDR_*     : word offsets inside the image-memory header
//   tod_t     : binary time of day {hh, mm, ss}, packed to match header word 0
//   dpa_state_e : scheduler FSM states
package dpa_pkg;

    localparam int unsigned HDR_TIME = 0;
    localparam int unsigned HDR_FB   = 1;
    localparam int unsigned HDR_NUM  = 2;
    localparam int unsigned HDR_TBL  = 3;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } tod_t;

    typedef enum logic [1:0] {
        StFetch,
        StRun,
        StIdleErr
    } dpa_state_e;

endpackage

// File: rtl/dpa_time_counter.sv
// Wall-clock time of day with a cycle prescaler.
//   clk, reset : clock, asynchronous active-high reset
//   load       : take load_value and restart the prescaler (wins over enable)
//   load_value : seed time of day
//   enable     : prescaler runs while high
//   tod        : current time of day
//   sec_tick   : one-cycle pulse, coincident with each time update
module dpa_time_counter
    import dpa_pkg::*;
#(
    parameter int unsigned CYCLES_PER_SEC = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  tod_t load_value,
    input  logic enable,
    output tod_t tod,
    output logic sec_tick
);

    localparam int unsigned PreW = $clog2(CYCLES_PER_SEC);

    logic [PreW-1:0] pre_q, pre_d;
    tod_t            tod_q, tod_d;
    logic            tick_q, tick_d;

    always_comb begin
        pre_d  = pre_q;
        tod_d  = tod_q;
        tick_d = 1'b0;
        if (load) begin
            pre_d = '0;
            tod_d = load_value;
        end else if (enable) begin
            if (pre_q == PreW'(CYCLES_PER_SEC - 1)) begin
                pre_d  = '0;
                tick_d = 1'b1;
                // >= rather than == so an out-of-range seed recovers on its first wrap
                if (tod_q.ss >= 8'd59) begin
                    tod_d.ss = 8'd0;
                    if (tod_q.mm >= 8'd59) begin
                        tod_d.mm = 8'd0;
                        tod_d.hh = (tod_q.hh >= 8'd23) ? 8'd0 : tod_q.hh + 8'd1;
                    end else begin
                        tod_d.mm = tod_q.mm + 8'd1;
                    end
                end else begin
                    tod_d.ss = tod_q.ss + 8'd1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            tod_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tod_q  <= tod_d;
            tick_q <= tick_d;
        end
    end

    assign tod      = tod_q;
    assign sec_tick = tick_q;

endmodule

// File: rtl/dpa_slide_scheduler.sv
// Photo album control front end: fetches the image-memory header after reset,
// runs the wall clock seeded from it and issues one slide request per period.
//   clk, reset        : clock, asynchronous active-high reset
//   im_a/im_wen/im_q  : image-memory read port (read data one cycle after address)
//   pause             : freezes slide timing, wall clock keeps running
//   hdr_done, cfg_err : header fetched / header photo_num was zero (levels)
//   fb_addr           : frame-buffer base from the header
//   time_hh/mm/ss     : time of day; sec_tick pulses once per second
//   req_*             : valid/ready slide request (index, address, size)
//   slide_miss        : pulse when a period expires with a request still pending
module dpa_slide_scheduler
    import dpa_pkg::*;
#(
    parameter int unsigned MAX_PHOTOS     = 4,
    parameter int unsigned CYCLES_PER_SEC = 1000000,
    parameter int unsigned SLIDE_SEC      = 2,
    parameter int unsigned AW             = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [AW-1:0]                 im_a,
    output logic                          im_wen,
    input  logic [23:0]                   im_q,
    input  logic                          pause,
    output logic                          hdr_done,
    output logic                          cfg_err,
    output logic [AW-1:0]                 fb_addr,
    output logic [7:0]                    time_hh,
    output logic [7:0]                    time_mm,
    output logic [7:0]                    time_ss,
    output logic                          sec_tick,
    output logic                          req_valid,
    input  logic                          req_ready,
    output logic [$clog2(MAX_PHOTOS)-1:0] req_idx,
    output logic [AW-1:0]                 req_addr,
    output logic [23:0]                   req_size,
    output logic                          slide_miss
);

    localparam int unsigned NumWords = HDR_TBL + 2 * MAX_PHOTOS;
    localparam int unsigned CntW     = $clog2(NumWords + 1);
    localparam int unsigned IdxW     = $clog2(MAX_PHOTOS);
    localparam int unsigned NumW     = $clog2(MAX_PHOTOS + 1);
    localparam int unsigned SlideW   = $clog2(SLIDE_SEC + 1);

    dpa_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    tod_t              seed_q, seed_d;
    logic [AW-1:0]     fb_q, fb_d;
    logic [NumW-1:0]   num_q, num_d;
    logic [AW-1:0]     addr_tbl_q [MAX_PHOTOS];
    logic [AW-1:0]     addr_tbl_d [MAX_PHOTOS];
    logic [23:0]       size_tbl_q [MAX_PHOTOS];
    logic [23:0]       size_tbl_d [MAX_PHOTOS];
    logic              hdr_done_q, hdr_done_d;
    logic              cfg_err_q, cfg_err_d;
    logic              req_valid_q, req_valid_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [AW-1:0]     req_addr_q, req_addr_d;
    logic [23:0]       req_size_q, req_size_d;
    logic [SlideW-1:0] slide_q, slide_d;
    logic              miss_q, miss_d;

    logic              tod_load;
    logic              accept;
    logic [IdxW-1:0]   idx_next;
    logic [31:0]       cap_idx;
    tod_t              tod;
    logic              tick;

    dpa_time_counter #(
        .CYCLES_PER_SEC(CYCLES_PER_SEC)
    ) u_time (
        .clk       (clk),
        .reset     (reset),
        .load      (tod_load),
        .load_value(seed_q),
        .enable    (state_q != StFetch),
        .tod       (tod),
        .sec_tick  (tick)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seed_d      = seed_q;
        fb_d        = fb_q;
        num_d       = num_q;
        addr_tbl_d  = addr_tbl_q;
        size_tbl_d  = size_tbl_q;
        hdr_done_d  = hdr_done_q;
        cfg_err_d   = cfg_err_q;
        req_valid_d = req_valid_q;
        idx_d       = idx_q;
        req_addr_d  = req_addr_q;
        req_size_d  = req_size_q;
        slide_d     = slide_q;
        miss_d      = 1'b0;
        tod_load    = 1'b0;
        accept      = req_valid_q && req_ready;
        idx_next    = (32'(idx_q) + 32'd1 >= 32'(num_q)) ? '0 : idx_q + 1'b1;
        // Data on im_q belongs to the address presented one cycle earlier
        cap_idx     = 32'(cnt_q) - 32'd1;

        unique case (state_q)
            StFetch: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q != '0) begin
                    if (cap_idx == HDR_TIME) seed_d = tod_t'(im_q);
                    if (cap_idx == HDR_FB)   fb_d   = AW'(im_q);
                    if (cap_idx == HDR_NUM) begin
                        num_d = (im_q > 24'(MAX_PHOTOS)) ? NumW'(MAX_PHOTOS) : NumW'(im_q);
                    end
                    for (int unsigned i = 0; i < MAX_PHOTOS; i++) begin
                        if (cap_idx == HDR_TBL + 2 * i)     addr_tbl_d[i] = AW'(im_q);
                        if (cap_idx == HDR_TBL + 2 * i + 1) size_tbl_d[i] = im_q;
                    end
                end
                if (cnt_q == CntW'(NumWords)) begin
                    // Last word lands now; entry 0 and photo_num were captured earlier
                    cnt_d      = cnt_q;
                    state_d    = StRun;
                    hdr_done_d = 1'b1;
                    tod_load   = 1'b1;
                    slide_d    = '0;
                    if (num_q == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        req_valid_d = 1'b1;
                        idx_d       = '0;
                        req_addr_d  = addr_tbl_q[0];
                        req_size_d  = size_tbl_q[0];
                    end
                end
            end
            StRun: begin
                if (num_q == '0) begin
                    state_d = StIdleErr;
                end else begin
                    if (accept) req_valid_d = 1'b0;
                    if (tick && !pause) begin
                        if (slide_q == SlideW'(SLIDE_SEC - 1)) begin
                            slide_d = '0;
                            // A transfer on the expiring cycle counts as taken
                            if (req_valid_q && !accept) begin
                                miss_d = 1'b1;
                            end else begin
                                req_valid_d = 1'b1;
                                idx_d       = idx_next;
                                req_addr_d  = addr_tbl_q[idx_next];
                                req_size_d  = size_tbl_q[idx_next];
                            end
                        end else begin
                            slide_d = slide_q + 1'b1;
                        end
                    end
                end
            end
            StIdleErr: begin
                state_d = StIdleErr;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StFetch;
            cnt_q       <= '0;
            seed_q      <= '0;
            fb_q        <= '0;
            num_q       <= '0;
            for (int unsigned i = 0; i < MAX_PHOTOS; i++) begin
                addr_tbl_q[i] <= '0;
                size_tbl_q[i] <= '0;
            end
            hdr_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            req_valid_q <= 1'b0;
            idx_q       <= '0;
            req_addr_q  <= '0;
            req_size_q  <= '0;
            slide_q     <= '0;
            miss_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            fb_q        <= fb_d;
            num_q       <= num_d;
            addr_tbl_q  <= addr_tbl_d;
            size_tbl_q  <= size_tbl_d;
            hdr_done_q  <= hdr_done_d;
            cfg_err_q   <= cfg_err_d;
            req_valid_q <= req_valid_d;
            idx_q       <= idx_d;
            req_addr_q  <= req_addr_d;
            req_size_q  <= req_size_d;
            slide_q     <= slide_d;
            miss_q      <= miss_d;
        end
    end

    assign im_a       = (state_q == StFetch) ? AW'(cnt_q) : '0;
    assign im_wen     = 1'b1;
    assign hdr_done   = hdr_done_q;
    assign cfg_err    = cfg_err_q;
    assign fb_addr    = fb_q;
    assign time_hh    = tod.hh;
    assign time_mm    = tod.mm;
    assign time_ss    = tod.ss;
    assign sec_tick   = tick;
    assign req_valid  = req_valid_q;
    assign req_idx    = idx_q;
    assign req_addr   = req_addr_q;
    assign req_size   = req_size_q;
    assign slide_miss = miss_q;

endmodule

// File: tb/tb_dpa_slide_scheduler.sv
// Self-checking bench for dpa_slide_scheduler (4 photos, 10 cycles/s, 1 s slides).
module tb_dpa_slide_scheduler;

    localparam int unsigned MAXP = 4;
    localparam int unsigned CPS  = 10;
    localparam int unsigned AW   = 20;
    localparam int unsigned N    = 3 + 2 * MAXP;
    localparam int unsigned IW   = $clog2(MAXP);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] im_a;
    logic          im_wen;
    logic [23:0]   im_q = '0;
    logic          pause = 1'b0;
    logic          hdr_done, cfg_err, sec_tick, req_valid, slide_miss;
    logic          req_ready = 1'b0;
    logic [AW-1:0] fb_addr, req_addr;
    logic [7:0]    time_hh, time_mm, time_ss;
    logic [IW-1:0] req_idx;
    logic [23:0]   req_size;

    dpa_slide_scheduler #(
        .MAX_PHOTOS    (MAXP),
        .CYCLES_PER_SEC(CPS),
        .SLIDE_SEC     (1),
        .AW            (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .im_a      (im_a),
        .im_wen    (im_wen),
        .im_q      (im_q),
        .pause     (pause),
        .hdr_done  (hdr_done),
        .cfg_err   (cfg_err),
        .fb_addr   (fb_addr),
        .time_hh   (time_hh),
        .time_mm   (time_mm),
        .time_ss   (time_ss),
        .sec_tick  (sec_tick),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .slide_miss(slide_miss)
    );

    always #5 clk = ~clk;

    // Image memory: registered read, data valid the cycle after the address
    logic [23:0] mem [N];
    always @(posedge clk) begin
        if (int'(im_a) < int'(N)) im_q <= mem[int'(im_a)];
        else                      im_q <= '0;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state
    int            num_eff;
    int            seed_s;
    logic [23:0]   cur_seed;
    bit            seed_ok;
    logic          m_valid, m_tick;
    int            m_idx, m_secs;
    int            n_miss, n_rise, n_xfer;
    logic [IW-1:0] xq [$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [23:0] secs_to_tod(int s);
        int d;
        d = s % 86400;
        return {8'(d / 3600), 8'((d / 60) % 60), 8'(d % 60)};
    endfunction

    task automatic set_hdr(logic [23:0] seed, int num);
        mem[0] = seed;
        mem[1] = 24'($urandom());
        mem[2] = 24'(num);
        for (int i = 0; i < int'(MAXP); i++) begin
            mem[3 + 2 * i] = 24'($urandom());
            mem[4 + 2 * i] = 24'($urandom());
        end
        num_eff  = (num > int'(MAXP)) ? int'(MAXP) : num;
        cur_seed = seed;
        seed_s   = int'(seed[23:16]) * 3600 + int'(seed[15:8]) * 60 + int'(seed[7:0]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_im_a", 64'(im_a), 64'(0));
        chk("rst_im_wen", 64'(im_wen), 64'(1));
        chk("rst_flags", 64'({hdr_done, cfg_err, sec_tick, req_valid, slide_miss}), 64'(0));
        chk("rst_time", 64'({time_hh, time_mm, time_ss}), 64'(0));
        chk("rst_req", 64'({fb_addr, req_idx, req_addr, req_size}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        cyc     = 0;
        m_valid = 1'b0;
        m_tick  = 1'b0;
        m_idx   = 0;
        m_secs  = seed_s;
        n_miss  = 0;
        n_rise  = 0;
        n_xfer  = 0;
        xq.delete();
        chk("im_a_c0", 64'(im_a), 64'(0));
    endtask

    // Advance one clock and compare every observable output against the model
    task automatic step();
        logic p_ready, p_pause, p_tick, acc, miss, raise;
        p_ready = req_ready;
        p_pause = pause;
        p_tick  = m_tick;
        acc     = m_valid && p_ready;
        if (acc) n_xfer++;
        if (req_valid && req_ready) xq.push_back(req_idx);
        @(posedge clk);
        #1;
        cyc++;
        raise = 1'b0;
        miss  = 1'b0;
        if (cyc == int'(N) + 1) begin
            if (num_eff != 0) begin
                raise = 1'b1;
                m_idx = 0;
            end
        end else if (cyc > int'(N) + 1 && p_tick && !p_pause && num_eff != 0) begin
            if (m_valid && !acc) begin
                miss = 1'b1;
            end else begin
                raise = 1'b1;
                m_idx = (m_idx + 1) % num_eff;
            end
        end
        m_valid = raise || (m_valid && !acc);
        m_tick  = (cyc > int'(N) + 1) && ((cyc - int'(N) - 1) % int'(CPS) == 0);
        if (miss) n_miss++;
        if (raise) n_rise++;

        if (cyc < int'(N)) chk("fetch_addr", 64'(im_a), 64'(cyc));
        chk("hdr_done", 64'(hdr_done), 64'(cyc >= int'(N) + 1));
        chk("cfg_err", 64'(cfg_err), 64'(cyc >= int'(N) + 1 && num_eff == 0));
        chk("req_valid", 64'(req_valid), 64'(m_valid));
        chk("sec_tick", 64'(sec_tick), 64'(m_tick));
        chk("slide_miss", 64'(slide_miss), 64'(miss));
        if (m_valid) begin
            chk("req_idx", 64'(req_idx), 64'(m_idx));
            chk("req_addr", 64'(req_addr), 64'(mem[3 + 2 * m_idx][AW-1:0]));
            chk("req_size", 64'(req_size), 64'(mem[4 + 2 * m_idx]));
        end
        if (cyc == int'(N) + 1) begin
            chk("fb_addr", 64'(fb_addr), 64'(mem[1][AW-1:0]));
            chk("time_load", 64'({time_hh, time_mm, time_ss}), 64'(cur_seed));
        end
        if (m_tick) begin
            m_secs++;
            if (seed_ok) chk("time_tick", 64'({time_hh, time_mm, time_ss}),
                             64'(secs_to_tod(m_secs)));
        end
    endtask

    typedef struct {
        logic [23:0] seed;
        int          num;
        logic        cfg;
        logic [23:0] t1;
        logic [23:0] t2;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{24'h173B3A, 3, 1'b0, 24'h173B3B, 24'h000000};
        vecs[1] = '{24'h000000, 0, 1'b1, 24'h000001, 24'h000002};
        vecs[2] = '{24'h050A46, 9, 1'b0, 24'h050B00, 24'h050B01};
        vecs[3] = '{24'h0C3B3B, 1, 1'b0, 24'h0D0000, 24'h0D0001};
        vecs[4] = '{24'h1E003B, 2, 1'b0, 24'h1E0100, 24'h1E0101};

        // Header / time-of-day vectors, including zero, clamped and out-of-range seeds
        for (int r = 0; r < 5; r++) begin
            set_hdr(vecs[r].seed, vecs[r].num);
            seed_ok   = 1'b0;
            req_ready = 1'b1;
            pause     = 1'b0;
            do_reset();
            while (cyc < int'(N) + 1 + 2 * int'(CPS)) begin
                step();
                if (cyc == int'(N) + 1) chk("tbl_cfg", 64'(cfg_err), 64'(vecs[r].cfg));
                if (cyc == int'(N) + 1 + int'(CPS))
                    chk("tbl_t1", 64'({time_hh, time_mm, time_ss}), 64'(vecs[r].t1));
                if (cyc == int'(N) + 1 + 2 * int'(CPS))
                    chk("tbl_t2", 64'({time_hh, time_mm, time_ss}), 64'(vecs[r].t2));
            end
        end

        // Always-ready downstream: idx 0,1,2,0,... and no misses
        set_hdr(24'h173B3A, 3);
        seed_ok   = 1'b1;
        req_ready = 1'b1;
        do_reset();
        while (xq.size() < 7 && cyc < 200) step();
        chk("seq_len", 64'(xq.size()), 64'(7));
        for (int i = 0; i < xq.size(); i++) chk("seq_idx", 64'(xq[i]), 64'(i % 3));
        chk("seq_miss", 64'(n_miss), 64'(0));

        // Stalled downstream for three periods
        req_ready = 1'b0;
        do_reset();
        while (cyc < int'(N) + 1 + 3 * int'(CPS) + 1) step();
        chk("stall_misses", 64'(n_miss), 64'(3));
        chk("stall_idx", 64'(req_idx), 64'(0));
        chk("stall_valid", 64'(req_valid), 64'(1));
        req_ready = 1'b1;
        while (cyc < int'(N) + 1 + 4 * int'(CPS) + 1) step();
        chk("after_stall_valid", 64'(req_valid), 64'(1));
        chk("after_stall_idx", 64'(req_idx), 64'(1));

        // Pause for 25 ticks mid-period
        do_reset();
        while (cyc < 27) step();
        begin
            int rises;
            rises = n_rise;
            pause = 1'b1;
            while (cyc < 277) step();
            chk("pause_no_req", 64'(n_rise), 64'(rises));
            chk("pause_time", 64'({time_hh, time_mm, time_ss}), 64'(secs_to_tod(seed_s + 26)));
            pause = 1'b0;
            while (cyc < 283) step();
            chk("resume_valid", 64'(req_valid), 64'(1));
            chk("resume_idx", 64'(req_idx), 64'(2));
        end

        // Reset while a request is pending
        req_ready = 1'b0;
        do_reset();
        while (cyc < 15) step();
        chk("pre_rst_valid", 64'(req_valid), 64'(1));
        do_reset();
        while (cyc < int'(N) + 2) step();

        // Randomized headers, handshake and pause against the model
        for (int it = 0; it < 6; it++) begin
            set_hdr({8'($urandom_range(23)), 8'($urandom_range(59)), 8'($urandom_range(59))},
                    int'($urandom_range(9)));
            seed_ok = 1'b1;
            pause   = 1'b0;
            do_reset();
            while (cyc < 200) begin
                req_ready = ($urandom_range(3) != 0);
                if ($urandom_range(39) == 0) pause = ~pause;
                step();
            end
        end
        pause = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
